// File: rtl/checker_rr_arbiter.sv
// checker_rr_arbiter: shares one cpu_checker between two character streams.
// Whole '^'..'#' records are granted in round-robin order, forwarded to the
// checker with the owner's freq, and the captured format_type is handed back.
module checker_rr_arbiter #(
  parameter int RESULT_LAT = 1,
  parameter int MAX_LEN    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_char0,
  input  logic [7:0]  req_char1,
  output logic [1:0]  req_ready,
  input  logic [15:0] cfg_freq0,
  input  logic [15:0] cfg_freq1,
  output logic [7:0]  chk_char,
  output logic [15:0] chk_freq,
  input  logic [1:0]  chk_format,
  output logic        busy,
  output logic        res_valid,
  output logic        res_id,
  output logic [1:0]  res_fmt,
  output logic        res_abort
);

  localparam logic [7:0] SOP_CHAR = 8'h5E;
  localparam logic [7:0] EOP_CHAR = 8'h23;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int LAT_W = (RESULT_LAT < 1) ? 1 : $clog2(RESULT_LAT + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESULT_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [7:0]        chk_char_q, chk_char_d;
  logic [15:0]       chk_freq_q, chk_freq_d;
  logic              res_valid_q, res_valid_d;
  logic              res_id_q, res_id_d;
  logic [1:0]        res_fmt_q, res_fmt_d;
  logic              res_abort_q, res_abort_d;

  logic              sop0, sop1, both_sop, any_sop, grant_id;
  logic [15:0]       grant_freq;
  logic              own_valid;
  logic [7:0]        own_char;
  logic [15:0]       own_freq;
  logic              overflow;

  // Decode start-of-record requests, the round-robin winner and the owner's stream
  always_comb begin
    sop0       = req_valid[0] && (req_char0 == SOP_CHAR);
    sop1       = req_valid[1] && (req_char1 == SOP_CHAR);
    both_sop   = sop0 && sop1;
    any_sop    = sop0 || sop1;
    grant_id   = both_sop ? ~last_owner_q : sop1;
    grant_freq = grant_id ? cfg_freq1 : cfg_freq0;
    own_valid  = owner_q ? req_valid[1] : req_valid[0];
    own_char   = owner_q ? req_char1 : req_char0;
    own_freq   = owner_q ? cfg_freq1 : cfg_freq0;
    overflow   = (len_q == LEN_MAX) && (own_char != SOP_CHAR);
  end

  // Next-state, handshake and result logic for the IDLE/OWN/WAIT record FSM
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    len_d        = len_q;
    lat_d        = lat_q;
    chk_char_d   = 8'h00;
    chk_freq_d   = chk_freq_q;
    res_valid_d  = 1'b0;
    res_id_d     = res_id_q;
    res_fmt_d    = res_fmt_q;
    res_abort_d  = res_abort_q;
    req_ready    = 2'b00;

    case (state_q)
      S_IDLE: begin
        req_ready[0] = req_valid[0] && !(both_sop && grant_id);
        req_ready[1] = req_valid[1] && !(both_sop && !grant_id);
        if (any_sop) begin
          state_d    = S_OWN;
          owner_d    = grant_id;
          len_d      = LEN_W'(1);
          chk_char_d = SOP_CHAR;
          chk_freq_d = grant_freq;
        end
      end

      S_OWN: begin
        if (!own_valid || overflow) begin
          state_d      = S_IDLE;
          res_valid_d  = 1'b1;
          res_abort_d  = 1'b1;
          res_fmt_d    = 2'b00;
          res_id_d     = owner_q;
          last_owner_d = owner_q;
        end else begin
          req_ready  = owner_q ? 2'b10 : 2'b01;
          chk_char_d = own_char;
          chk_freq_d = own_freq;
          len_d      = (own_char == SOP_CHAR) ? LEN_W'(1) : len_q + LEN_W'(1);
          if (own_char == EOP_CHAR) begin
            state_d = S_WAIT;
            lat_d   = '0;
          end
        end
      end

      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d      = S_IDLE;
          res_valid_d  = 1'b1;
          res_abort_d  = 1'b0;
          res_fmt_d    = chk_format;
          res_id_d     = owner_q;
          last_owner_d = owner_q;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any record in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      len_q        <= '0;
      lat_q        <= '0;
      chk_char_q   <= 8'h00;
      chk_freq_q   <= 16'h0000;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_fmt_q    <= 2'b00;
      res_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      len_q        <= len_d;
      lat_q        <= lat_d;
      chk_char_q   <= chk_char_d;
      chk_freq_q   <= chk_freq_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_fmt_q    <= res_fmt_d;
      res_abort_q  <= res_abort_d;
    end
  end

  assign chk_char  = chk_char_q;
  assign chk_freq  = chk_freq_q;
  assign busy      = (state_q != S_IDLE);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_fmt   = res_fmt_q;
  assign res_abort = res_abort_q;

endmodule

// File: tb/tb_checker_rr_arbiter.sv
// Testbench for checker_rr_arbiter: a directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a record-level model.
module tb_checker_rr_arbiter;

  localparam int RESULT_LAT = 1;
  localparam int MAX_LEN    = 64;
  localparam logic [7:0] SOP = 8'h5E;
  localparam logic [7:0] EOP = 8'h23;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [7:0]  req_char0;
  logic [7:0]  req_char1;
  logic [1:0]  req_ready;
  logic [15:0] cfg_freq0;
  logic [15:0] cfg_freq1;
  logic [7:0]  chk_char;
  logic [15:0] chk_freq;
  logic [1:0]  chk_format;
  logic        busy;
  logic        res_valid;
  logic        res_id;
  logic [1:0]  res_fmt;
  logic        res_abort;

  int n_checks = 0;
  int n_errors = 0;

  checker_rr_arbiter #(.RESULT_LAT(RESULT_LAT), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_char0  (req_char0),
    .req_char1  (req_char1),
    .req_ready  (req_ready),
    .cfg_freq0  (cfg_freq0),
    .cfg_freq1  (cfg_freq1),
    .chk_char   (chk_char),
    .chk_freq   (chk_freq),
    .chk_format (chk_format),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_fmt    (res_fmt),
    .res_abort  (res_abort)
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [1:0] valid;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] exp_ready;
    logic [7:0] exp_char;
    logic       exp_busy;
    logic       exp_rv;
    logic       exp_rid;
    logic       exp_rab;
    logic [1:0] exp_rfmt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] v, logic [7:0] c0, logic [7:0] c1,
                              logic [1:0] rdy, logic [7:0] ch, logic bsy,
                              logic rv, logic rid, logic rab, logic [1:0] rfmt);
    vec_t t;
    t.valid = v;      t.c0 = c0;        t.c1 = c1;
    t.exp_ready = rdy; t.exp_char = ch; t.exp_busy = bsy;
    t.exp_rv = rv;    t.exp_rid = rid;  t.exp_rab = rab; t.exp_rfmt = rfmt;
    return t;
  endfunction

  // Drive requester inputs, then let combinational outputs settle
  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1);
    req_valid = v;
    req_char0 = c0;
    req_char1 = c1;
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and sample registered outputs 2 time units later
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic doReset;
    reset = 1'b0;
    req_valid = 2'b00;
    req_char0 = 8'h00;
    req_char1 = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // ------------------------------------------------------------------
  // Record-level reference model: owner -1 means nobody holds the checker;
  // the result is due RESULT_LAT+1 edges after the edge that took '#'.
  // ------------------------------------------------------------------
  int         m_owner, m_last, m_len, m_hash_edge, m_edge;
  bit         m_waiting;
  logic [7:0] e_char;
  logic [15:0] e_freq;
  logic       e_rv, e_rid, e_rab;
  logic [1:0] e_rfmt;

  task automatic modelReset;
    m_owner = -1; m_last = 1; m_len = 0; m_hash_edge = 0; m_edge = 0;
    m_waiting = 1'b0;
    e_char = 8'h00; e_freq = 16'h0000;
    e_rv = 1'b0; e_rid = 1'b0; e_rab = 1'b0; e_rfmt = 2'b00;
  endtask

  function automatic int sopWinner(logic [1:0] v, logic [7:0] c0, logic [7:0] c1);
    bit s0, s1;
    s0 = v[0] && (c0 == SOP);
    s1 = v[1] && (c1 == SOP);
    if (s0 && s1) return 1 - m_last;
    if (s0) return 0;
    if (s1) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] modelReady(logic [1:0] v, logic [7:0] c0, logic [7:0] c1);
    logic [7:0] oc;
    if (m_waiting) return 2'b00;
    if (m_owner < 0) begin
      if (v[0] && c0 == SOP && v[1] && c1 == SOP)
        return (sopWinner(v, c0, c1) == 0) ? 2'b01 : 2'b10;
      return v;
    end
    oc = (m_owner == 1) ? c1 : c0;
    if (v[m_owner] && !(m_len >= MAX_LEN && oc != SOP))
      return (m_owner == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic modelEdge(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [1:0] fmt);
    int w;
    logic [7:0] oc;
    m_edge++;
    e_rv = 1'b0;
    e_char = 8'h00;
    if (m_waiting) begin
      if (m_edge == m_hash_edge + 1 + RESULT_LAT) begin
        e_rv = 1'b1; e_rab = 1'b0; e_rfmt = fmt; e_rid = m_owner[0];
        m_last = m_owner; m_owner = -1; m_waiting = 1'b0;
      end
    end else if (m_owner < 0) begin
      w = sopWinner(v, c0, c1);
      if (w >= 0) begin
        m_owner = w; m_len = 1; e_char = SOP;
        e_freq = (w == 1) ? cfg_freq1 : cfg_freq0;
      end
    end else begin
      oc = (m_owner == 1) ? c1 : c0;
      if (!v[m_owner] || (m_len >= MAX_LEN && oc != SOP)) begin
        e_rv = 1'b1; e_rab = 1'b1; e_rfmt = 2'b00; e_rid = m_owner[0];
        m_last = m_owner; m_owner = -1;
      end else begin
        e_char = oc;
        e_freq = (m_owner == 1) ? cfg_freq1 : cfg_freq0;
        m_len = (oc == SOP) ? 1 : m_len + 1;
        if (oc == EOP) begin
          m_waiting = 1'b1;
          m_hash_edge = m_edge;
        end
      end
    end
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic addChar(input int who, input logic [7:0] c);
    if (who == 0) q0.push_back(c);
    else q1.push_back(c);
  endtask

  // Queue one record (optionally preceded by a junk char) for a requester
  task automatic pushRecord(input int who);
    string alpha;
    int n;
    alpha = "0123456789abcdef@:*<=x";
    if ($urandom_range(0, 7) == 0) addChar(who, alpha[$urandom_range(0, alpha.len() - 1)]);
    addChar(who, SOP);
    n = ($urandom_range(0, 29) == 0) ? 68 : int'($urandom_range(0, 20));
    for (int k = 0; k < n; k++) addChar(who, alpha[$urandom_range(0, alpha.len() - 1)]);
    addChar(who, EOP);
  endtask

  // Main test sequence
  initial begin
    string s;
    logic [7:0] ch;
    logic [1:0] v, r, fmt;
    int n_fwd;

    reset = 1'b0;
    req_valid = 2'b00;
    req_char0 = 8'h00;
    req_char1 = 8'h00;
    cfg_freq0 = 16'h0100;
    cfg_freq1 = 16'hBEEF;
    chk_format = 2'b01;
    #2;
    checkOutput("reset_chk_char", 32'(chk_char), 32'h0);
    checkOutput("reset_chk_freq", 32'(chk_freq), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_res_valid", 32'(res_valid), 32'h0);
    checkOutput("reset_res_id", 32'(res_id), 32'h0);
    checkOutput("reset_res_fmt", 32'(res_fmt), 32'h0);
    checkOutput("reset_res_abort", 32'(res_abort), 32'h0);
    doReset();

    // Directed vector table: resync, contention, bubble abort, mixed '^'/junk
    tbl.push_back(mk(2'b10, 8'h00, "x", 2'b10, 8'h00, 0, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b10, 8'h00, "y", 2'b10, 8'h00, 0, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b10, 8'h00, "z", 2'b10, 8'h00, 0, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b10, 8'h00, SOP, 2'b10, SOP,   1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b10, 8'h00, "1", 2'b10, "1",   1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b10, 8'h00, EOP, 2'b10, EOP,   1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 1, 1, 0, 2'b01));
    tbl.push_back(mk(2'b11, SOP, SOP, 2'b01, SOP,     1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b11, EOP, SOP, 2'b01, EOP,     1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b10, 8'h00, SOP, 2'b00, 8'h00, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b10, 8'h00, SOP, 2'b00, 8'h00, 0, 1, 0, 0, 2'b01));
    tbl.push_back(mk(2'b11, SOP, SOP, 2'b10, SOP,     1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b11, SOP, "Q", 2'b10, "Q",     1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b01, SOP, 8'h00, 2'b00, 8'h00, 0, 1, 1, 1, 2'b00));
    tbl.push_back(mk(2'b01, SOP, 8'h00, 2'b01, SOP,   1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b01, "k", 8'h00, 2'b01, "k",   1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b11, EOP, SOP, 2'b01, EOP,     1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 1, 0, 0, 2'b01));
    tbl.push_back(mk(2'b11, "a", SOP, 2'b11, SOP,     1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b10, 8'h00, EOP, 2'b10, EOP,   1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 1, 1, 0, 2'b01));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].valid, tbl[i].c0, tbl[i].c1);
      checkOutput($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      tick();
      checkOutput($sformatf("tbl%0d_chk_char", i), 32'(chk_char), 32'(tbl[i].exp_char));
      checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      checkOutput($sformatf("tbl%0d_res_valid", i), 32'(res_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) begin
        checkOutput($sformatf("tbl%0d_res_id", i), 32'(res_id), 32'(tbl[i].exp_rid));
        checkOutput($sformatf("tbl%0d_res_abort", i), 32'(res_abort), 32'(tbl[i].exp_rab));
        checkOutput($sformatf("tbl%0d_res_fmt", i), 32'(res_fmt), 32'(tbl[i].exp_rfmt));
      end
    end

    // Full trace record from requester 0 replayed on chk_char with one cycle latency
    doReset();
    cfg_freq0 = 16'd256;
    chk_format = 2'b10;
    s = "^8552@0000a19b: *0000fd55<=000035de#";
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(2'b01, s[i], 8'h00);
      checkOutput("trace_ready", 32'(req_ready), 32'h1);
      tick();
      checkOutput("trace_chk_char", 32'(chk_char), 32'(s[i]));
      checkOutput("trace_chk_freq", 32'(chk_freq), 32'd256);
    end
    applyStimulus(2'b00, 8'h00, 8'h00);
    tick();
    checkOutput("trace_wait_busy", 32'(busy), 32'h1);
    checkOutput("trace_wait_res_valid", 32'(res_valid), 32'h0);
    tick();
    checkOutput("trace_res_valid", 32'(res_valid), 32'h1);
    checkOutput("trace_res_id", 32'(res_id), 32'h0);
    checkOutput("trace_res_fmt", 32'(res_fmt), 32'h2);
    checkOutput("trace_res_abort", 32'(res_abort), 32'h0);
    tick();
    checkOutput("trace_res_strobe_drop", 32'(res_valid), 32'h0);
    checkOutput("trace_res_fmt_hold", 32'(res_fmt), 32'h2);

    // 70-char record with no '#': 64 forwarded, the 65th refused and the record aborted
    doReset();
    n_fwd = 0;
    for (int i = 0; i < 70; i++) begin
      ch = (i == 0) ? SOP : 8'h61 + 8'(i % 26);
      applyStimulus(2'b01, ch, 8'h00);
      if (i < MAX_LEN) begin
        checkOutput("ovf_ready", 32'(req_ready), 32'h1);
        tick();
        checkOutput("ovf_chk_char", 32'(chk_char), 32'(ch));
        if (chk_char != 8'h00) n_fwd++;
      end else if (i == MAX_LEN) begin
        checkOutput("ovf_65th_ready", 32'(req_ready), 32'h0);
        tick();
        checkOutput("ovf_chk_char_bubble", 32'(chk_char), 32'h0);
        checkOutput("ovf_res_valid", 32'(res_valid), 32'h1);
        checkOutput("ovf_res_abort", 32'(res_abort), 32'h1);
        checkOutput("ovf_res_id", 32'(res_id), 32'h0);
        checkOutput("ovf_res_fmt", 32'(res_fmt), 32'h0);
        checkOutput("ovf_busy", 32'(busy), 32'h0);
      end else begin
        checkOutput("ovf_tail_discard_ready", 32'(req_ready), 32'h1);
        tick();
        checkOutput("ovf_tail_chk_char", 32'(chk_char), 32'h0);
      end
    end
    checkOutput("ovf_forwarded_count", 32'(n_fwd), 32'(MAX_LEN));

    // Reset in the middle of a record, then check last_owner restarts at 1
    doReset();
    applyStimulus(2'b01, SOP, 8'h00); tick();
    applyStimulus(2'b01, EOP, 8'h00); tick();
    applyStimulus(2'b00, 8'h00, 8'h00); tick();
    tick();
    applyStimulus(2'b10, 8'h00, SOP); tick();
    applyStimulus(2'b10, 8'h00, "a"); tick();
    applyStimulus(2'b10, 8'h00, "b"); tick();
    checkOutput("midrst_pre_busy", 32'(busy), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_chk_char", 32'(chk_char), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_res_valid", 32'(res_valid), 32'h0);
    req_valid = 2'b00;
    @(posedge clk);
    #2;
    reset = 1'b1;
    applyStimulus(2'b11, SOP, SOP);
    checkOutput("midrst_regrant_ready", 32'(req_ready), 32'h1);
    tick();
    checkOutput("midrst_regrant_char", 32'(chk_char), 32'(SOP));
    checkOutput("midrst_regrant_busy", 32'(busy), 32'h1);
    checkOutput("midrst_no_result", 32'(res_valid), 32'h0);

    // Randomized traffic from both requesters against the reference model
    doReset();
    modelReset();
    cfg_freq0 = 16'($urandom_range(1, 16'hFFFF));
    cfg_freq1 = 16'($urandom_range(1, 16'hFFFF));
    q0.delete();
    q1.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (q0.size() == 0) pushRecord(0);
      if (q1.size() == 0) pushRecord(1);
      v[0] = ($urandom_range(0, 63) != 0);
      v[1] = ($urandom_range(0, 63) != 0);
      fmt = 2'($urandom_range(0, 3));
      chk_format = fmt;
      applyStimulus(v, q0[0], q1[0]);
      r = modelReady(v, q0[0], q1[0]);
      checkOutput("rnd_ready", 32'(req_ready), 32'(r));
      tick();
      modelEdge(v, q0[0], q1[0], fmt);
      checkOutput("rnd_chk_char", 32'(chk_char), 32'(e_char));
      checkOutput("rnd_chk_freq", 32'(chk_freq), 32'(e_freq));
      checkOutput("rnd_busy", 32'(busy), 32'(m_owner >= 0));
      checkOutput("rnd_res_valid", 32'(res_valid), 32'(e_rv));
      if (e_rv) begin
        checkOutput("rnd_res_id", 32'(res_id), 32'(e_rid));
        checkOutput("rnd_res_fmt", 32'(res_fmt), 32'(e_rfmt));
        checkOutput("rnd_res_abort", 32'(res_abort), 32'(e_rab));
      end
      if (r[0]) void'(q0.pop_front());
      if (r[1]) void'(q1.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
